// File: rtl/cache_req_arbiter.sv
// ---------------------------------------------------------------------------
// cache_req_arbiter
//
// Shares one cache controller between NUM_REQ requesters. In IDLE the next
// requester is picked round-robin (first set req bit after the last served
// index, wrapping). Its we/addr/wdata are latched and offered to the cache
// with a valid/ready handshake. The arbiter then waits for cache_done, with
// a timeout, and returns data, hit flag and error to that requester only.
// All outputs are registered.
//
// Optional feature: define CACHE_ARB_STATS_EN to build the saturating
// hit/miss counters. Without it stat_hits/stat_misses are constant 8'h00.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   req, req_we       per-requester request level and write enable
//   req_addr          flattened, requester i at [i*ADDR_W +: ADDR_W]
//   req_wdata         flattened, requester i at [i*DATA_W +: DATA_W]
//   gnt               one-hot accept pulse (first ISSUE cycle)
//   done              one-hot completion pulse (RESP cycle)
//   rsp_rdata/hit/err response data, hit flag, timeout flag; held until
//                     the next completion
//   busy              arbiter is not idle
//   cache_valid/we/addr/wdata  request towards the cache
//   cache_ready       cache accepts the request
//   cache_done/rdata/hit       cache completion and its result
//   stat_hits/misses  saturating completion counters
// ---------------------------------------------------------------------------
module cache_req_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 7,
  parameter int TIMEOUT_W = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         req_we,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [NUM_REQ-1:0]         done,
  output logic [DATA_W-1:0]          rsp_rdata,
  output logic                       rsp_hit,
  output logic                       rsp_err,
  output logic                       busy,
  output logic                       cache_valid,
  output logic                       cache_we,
  output logic [ADDR_W-1:0]          cache_addr,
  output logic [DATA_W-1:0]          cache_wdata,
  input  logic                       cache_ready,
  input  logic                       cache_done,
  input  logic [DATA_W-1:0]          cache_rdata,
  input  logic                       cache_hit,
  output logic [7:0]                 stat_hits,
  output logic [7:0]                 stat_misses
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  // Timer holds the number of completed WAIT cycles; when it reads
  // 2**TIMEOUT_W-2 the current cycle is the last allowed one.
  localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'((2 ** TIMEOUT_W) - 2);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t               state, state_d;
  logic [IDX_W-1:0]     idx, idx_d;
  logic [IDX_W-1:0]     last, last_d;
  logic [TIMEOUT_W-1:0] timer, timer_d;

  logic [NUM_REQ-1:0]   gnt_d, done_d;
  logic [DATA_W-1:0]    rsp_rdata_d;
  logic                 rsp_hit_d, rsp_err_d;
  logic                 cache_valid_d, cache_we_d;
  logic [ADDR_W-1:0]    cache_addr_d;
  logic [DATA_W-1:0]    cache_wdata_d;

  logic                 arb_hit;
  logic [IDX_W-1:0]     arb_idx;
  int                   cand;

  // Round-robin pick: first set req bit scanning upward from last+1.
  always_comb begin
    arb_hit = 1'b0;
    arb_idx = '0;
    cand    = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = (int'(last) + i) % NUM_REQ;
      if (!arb_hit && req[cand]) begin
        arb_hit = 1'b1;
        arb_idx = IDX_W'(cand);
      end
    end
  end

  // Next-state and next-output logic; everything holds by default.
  always_comb begin
    state_d       = state;
    idx_d         = idx;
    last_d        = last;
    timer_d       = timer;
    gnt_d         = '0;
    done_d        = '0;
    rsp_rdata_d   = rsp_rdata;
    rsp_hit_d     = rsp_hit;
    rsp_err_d     = rsp_err;
    cache_valid_d = 1'b0;
    cache_we_d    = cache_we;
    cache_addr_d  = cache_addr;
    cache_wdata_d = cache_wdata;

    case (state)
      S_IDLE: begin
        if (arb_hit) begin
          idx_d          = arb_idx;
          cache_we_d     = req_we[arb_idx];
          cache_addr_d   = req_addr[arb_idx*ADDR_W +: ADDR_W];
          cache_wdata_d  = req_wdata[arb_idx*DATA_W +: DATA_W];
          gnt_d[arb_idx] = 1'b1;
          cache_valid_d  = 1'b1;
          state_d        = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // cache_done is deliberately ignored until the request is accepted.
        if (cache_ready) begin
          timer_d = '0;
          state_d = S_WAIT;
        end else begin
          cache_valid_d = 1'b1;
        end
      end
      S_WAIT: begin
        timer_d = timer + TIMEOUT_W'(1);
        if (cache_done) begin
          rsp_rdata_d = cache_rdata;
          rsp_hit_d   = cache_hit;
          rsp_err_d   = 1'b0;
          done_d[idx] = 1'b1;
          state_d     = S_RESP;
        end else if (timer == TMO_LAST) begin
          rsp_rdata_d = '0;
          rsp_hit_d   = 1'b0;
          rsp_err_d   = 1'b1;
          done_d[idx] = 1'b1;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        last_d  = idx;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      idx         <= '0;
      last        <= IDX_W'(NUM_REQ - 1);
      timer       <= '0;
      gnt         <= '0;
      done        <= '0;
      rsp_rdata   <= '0;
      rsp_hit     <= 1'b0;
      rsp_err     <= 1'b0;
      busy        <= 1'b0;
      cache_valid <= 1'b0;
      cache_we    <= 1'b0;
      cache_addr  <= '0;
      cache_wdata <= '0;
    end else begin
      state       <= state_d;
      idx         <= idx_d;
      last        <= last_d;
      timer       <= timer_d;
      gnt         <= gnt_d;
      done        <= done_d;
      rsp_rdata   <= rsp_rdata_d;
      rsp_hit     <= rsp_hit_d;
      rsp_err     <= rsp_err_d;
      busy        <= (state_d != S_IDLE);
      cache_valid <= cache_valid_d;
      cache_we    <= cache_we_d;
      cache_addr  <= cache_addr_d;
      cache_wdata <= cache_wdata_d;
    end
  end

`ifdef CACHE_ARB_STATS_EN
  // Only real cache completions are counted; timeouts are not.
  logic       hit_evt, miss_evt;
  logic [7:0] hits_q, misses_q;

  assign hit_evt  = (state == S_WAIT) && cache_done && cache_hit;
  assign miss_evt = (state == S_WAIT) && cache_done && !cache_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hits_q   <= 8'h00;
      misses_q <= 8'h00;
    end else begin
      if (hit_evt && (hits_q != 8'hFF))
        hits_q <= hits_q + 8'd1;
      if (miss_evt && (misses_q != 8'hFF))
        misses_q <= misses_q + 8'd1;
    end
  end

  assign stat_hits   = hits_q;
  assign stat_misses = misses_q;
`else
  assign stat_hits   = 8'h00;
  assign stat_misses = 8'h00;
`endif

endmodule

// File: tb/tb_cache_req_arbiter.sv
// Directed testbench for cache_req_arbiter (NUM_REQ=2, ADDR_W=4, DATA_W=7,
// TIMEOUT_W=4). Inputs change on the falling edge, outputs are sampled on
// the falling edge, the design acts on the rising edge.
module tb_cache_req_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req, req_we;
  logic [7:0]  req_addr;
  logic [13:0] req_wdata;
  logic [1:0]  gnt, done;
  logic [6:0]  rsp_rdata;
  logic        rsp_hit, rsp_err, busy;
  logic        cache_valid, cache_we;
  logic [3:0]  cache_addr;
  logic [6:0]  cache_wdata;
  logic        cache_ready, cache_done, cache_hit;
  logic [6:0]  cache_rdata;
  logic [7:0]  stat_hits, stat_misses;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  cache_req_arbiter #(
    .NUM_REQ(2), .ADDR_W(4), .DATA_W(7), .TIMEOUT_W(4)
  ) dut (
    .clk(clk), .rst(rst),
    .req(req), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .gnt(gnt), .done(done),
    .rsp_rdata(rsp_rdata), .rsp_hit(rsp_hit), .rsp_err(rsp_err), .busy(busy),
    .cache_valid(cache_valid), .cache_we(cache_we),
    .cache_addr(cache_addr), .cache_wdata(cache_wdata),
    .cache_ready(cache_ready), .cache_done(cache_done),
    .cache_rdata(cache_rdata), .cache_hit(cache_hit),
    .stat_hits(stat_hits), .stat_misses(stat_misses)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One rising edge, then return at the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called in the grant cycle with cache_ready=1: accept, complete one
  // cycle later with the given data/hit, then return to IDLE.
  task automatic complete(input int id, input logic [6:0] rd, input logic h, input string tag);
    tick();
    chk({tag, "_wait_valid"}, 32'(cache_valid), 32'h0);
    chk({tag, "_wait_gnt"}, 32'(gnt), 32'h0);
    cache_done  = 1'b1;
    cache_rdata = rd;
    cache_hit   = h;
    tick();
    chk({tag, "_done"}, 32'(done), 32'(1 << id));
    chk({tag, "_rdata"}, 32'(rsp_rdata), 32'(rd));
    chk({tag, "_hit"}, 32'(rsp_hit), 32'(h));
    chk({tag, "_err"}, 32'(rsp_err), 32'h0);
    cache_done = 1'b0;
    tick();
    chk({tag, "_done_clr"}, 32'(done), 32'h0);
    chk({tag, "_idle"}, 32'(busy), 32'h0);
  endtask

  // Single-requester read transaction from IDLE.
  task automatic txn(input int id, input logic [6:0] rd, input logic h, input string tag);
    req         = 2'(1 << id);
    cache_ready = 1'b1;
    tick();
    chk({tag, "_gnt"}, 32'(gnt), 32'(1 << id));
    req = 2'b00;
    complete(id, rd, h, tag);
  endtask

  initial begin
    rst = 1'b1; req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    cache_ready = 1'b0; cache_done = 1'b0; cache_rdata = '0; cache_hit = 1'b0;
    tick();
    tick();
    // Reset state
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_valid", 32'(cache_valid), 32'h0);
    chk("rst_addr", 32'(cache_addr), 32'h0);
    chk("rst_rdata", 32'(rsp_rdata), 32'h0);
    chk("rst_err", 32'(rsp_err), 32'h0);
    chk("rst_stat", 32'({stat_hits, stat_misses}), 32'h0);
    rst = 1'b0;
    tick();

    // Contention: both request continuously, grants alternate from 0.
    req = 2'b11; req_addr = 8'h93; cache_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rr_gnt", 32'(gnt), 32'((k % 2) ? 2 : 1));
      if (k == 3) req = 2'b00;
      complete(k % 2, 7'(7'h10 + k), k[0], "rr");
    end

    // Single read: addr 5, hit, data 2A; gnt one edge after req, done two later.
    req = 2'b01; req_we = 2'b00; req_addr = 8'h05; cache_ready = 1'b1;
    tick();
    chk("rd_gnt", 32'(gnt), 32'h1);
    chk("rd_valid", 32'(cache_valid), 32'h1);
    chk("rd_addr", 32'(cache_addr), 32'h5);
    chk("rd_we", 32'(cache_we), 32'h0);
    chk("rd_busy", 32'(busy), 32'h1);
    req = 2'b00;
    complete(0, 7'h2A, 1'b1, "rd");
    tick();
    chk("rd_hold", 32'(rsp_rdata), 32'h2A);

    // Stall: requester 1 writes 55 to addr A, cache_ready low for 5 cycles.
    req = 2'b10; req_we = 2'b10; req_addr = 8'hA0; req_wdata = {7'h55, 7'h00};
    cache_ready = 1'b0;
    tick();
    req = 2'b00; req_we = 2'b00; req_addr = 8'h3C; req_wdata = '1;
    for (int i = 0; i < 5; i++) begin
      chk("st_gnt", 32'(gnt), (i == 0) ? 32'h2 : 32'h0);
      chk("st_valid", 32'(cache_valid), 32'h1);
      chk("st_addr", 32'(cache_addr), 32'hA);
      chk("st_we", 32'(cache_we), 32'h1);
      chk("st_wdata", 32'(cache_wdata), 32'h55);
      tick();
    end
    chk("st_valid6", 32'(cache_valid), 32'h1);
    cache_ready = 1'b1;
    complete(1, 7'h55, 1'b0, "st");

    // Timeout: no cache_done; completion after 15 WAIT cycles with err.
    cache_rdata = 7'h7F;
    req = 2'b01; req_addr = 8'h03;
    tick();
    chk("to_gnt", 32'(gnt), 32'h1);
    req = 2'b00;
    tick();
    for (int n = 1; n <= 15; n++) begin
      chk("to_nodone", 32'(done), 32'h0);
      tick();
    end
    chk("to_done", 32'(done), 32'h1);
    chk("to_err", 32'(rsp_err), 32'h1);
    chk("to_rdata", 32'(rsp_rdata), 32'h0);
    chk("to_hit", 32'(rsp_hit), 32'h0);
    tick();
    chk("to_done_clr", 32'(done), 32'h0);
    txn(1, 7'h31, 1'b1, "to_next");

    // Reset in WAIT: outputs clear at once, no done, pointer back to 1.
    req = 2'b10; req_addr = 8'hE0;
    tick();
    chk("rw_gnt", 32'(gnt), 32'h2);
    req = 2'b00;
    tick();
    tick();
    chk("rw_busy", 32'(busy), 32'h1);
    chk("rw_addr", 32'(cache_addr), 32'hE);
    rst = 1'b1;
    #1;
    chk("rw_busy0", 32'(busy), 32'h0);
    chk("rw_addr0", 32'(cache_addr), 32'h0);
    chk("rw_rdata0", 32'(rsp_rdata), 32'h0);
    chk("rw_done0", 32'(done), 32'h0);
    cache_done = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("rw_nodone1", 32'(done), 32'h0);
    cache_done = 1'b0;
    tick();
    chk("rw_nodone2", 32'(done), 32'h0);
    chk("rw_idle", 32'(busy), 32'h0);
    req = 2'b11;
    tick();
    chk("rw_gnt0", 32'(gnt), 32'h1);
    req = 2'b00;
    complete(0, 7'h11, 1'b0, "rw");

    // Statistics: counters restart from reset.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    txn(0, 7'h01, 1'b1, "sx");
    txn(1, 7'h02, 1'b0, "sx");
    txn(0, 7'h03, 1'b1, "sx");
    txn(1, 7'h04, 1'b1, "sx");
    txn(0, 7'h05, 1'b0, "sx");
`ifdef CACHE_ARB_STATS_EN
    chk("stat_hits3", 32'(stat_hits), 32'd3);
    chk("stat_misses2", 32'(stat_misses), 32'd2);
`else
    chk("stat_hits_off", 32'(stat_hits), 32'd0);
    chk("stat_misses_off", 32'(stat_misses), 32'd0);
`endif
    for (int j = 0; j < 300; j++) txn(j % 2, 7'h40, 1'b1, "sat");
`ifdef CACHE_ARB_STATS_EN
    chk("stat_hits_sat", 32'(stat_hits), 32'hFF);
    chk("stat_misses_keep", 32'(stat_misses), 32'd2);
`else
    chk("stat_hits_off2", 32'(stat_hits), 32'd0);
    chk("stat_misses_off2", 32'(stat_misses), 32'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
